// File: rtl/vlc_bit_packer_if.sv
// Codeword input / packed-word output bundle for vlc_bit_packer.
// master = upstream codeword source, slave = the packer.
interface vlc_bit_packer_if;
    logic        in_valid;
    logic [31:0] in_code;
    logic [5:0]  in_len;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_word;
    logic        flush_done;
    logic [31:0] total_bits;
    logic        len_err;

    modport master (
        output in_valid, in_code, in_len, flush,
        input  out_valid, out_word, flush_done, total_bits, len_err
    );

    modport slave (
        input  in_valid, in_code, in_len, flush,
        output out_valid, out_word, flush_done, total_bits, len_err
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codewords into an MSB-first stream of
// 32-bit words, with an end-of-slice flush that zero-pads the final word.
module vlc_bit_packer (
    input  logic              clk,
    input  logic              reset,
    vlc_bit_packer_if.slave   bus
);
    typedef enum logic {RUN, FLUSH_TAIL} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_acc, w_acc_nxt;
    logic [5:0]  r_fill, w_fill_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_out_word, w_out_word_nxt;
    logic        r_flush_done, w_flush_done_nxt;
    logic [31:0] r_total, w_total_nxt;
    logic        r_len_err, w_len_err_nxt;

    logic        w_run, w_len_bad, w_accept, w_full;
    logic [63:0] w_mask, w_code, w_acc_app;
    logic [6:0]  w_sum, w_shamt;

    assign w_run     = (r_state == RUN);
    assign w_len_bad = w_run && bus.in_valid && (bus.in_len > 6'd32);
    assign w_accept  = w_run && bus.in_valid && !w_len_bad;
    assign w_mask    = (64'd1 << bus.in_len) - 64'd1;
    assign w_code    = {32'd0, bus.in_code} & w_mask;
    assign w_sum     = {1'b0, r_fill} + (w_accept ? {1'b0, bus.in_len} : 7'd0);
    // New bits land directly below the occupied MSB-aligned region.
    assign w_shamt   = 7'd64 - w_sum;
    assign w_acc_app = w_accept ? (r_acc | (w_code << w_shamt)) : r_acc;
    assign w_full    = (w_sum >= 7'd32);

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_fill_nxt       = r_fill;
        w_out_valid_nxt  = 1'b0;
        w_out_word_nxt   = r_out_word;
        w_flush_done_nxt = 1'b0;
        w_total_nxt      = r_flush_done ? 32'd0 : r_total;
        w_len_err_nxt    = r_len_err | w_len_bad;

        case (r_state)
            RUN: begin
                if (w_accept)
                    w_total_nxt = w_total_nxt + {26'd0, bus.in_len};
                w_acc_nxt  = w_acc_app;
                w_fill_nxt = w_sum[5:0];
                if (w_full) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_word_nxt  = w_acc_app[63:32];
                    w_acc_nxt       = {w_acc_app[31:0], 32'd0};
                    w_fill_nxt      = {1'b0, w_sum[4:0]};
                end
                if (bus.flush) begin
                    if (w_full) begin
                        w_state_nxt = FLUSH_TAIL;
                    end else begin
                        w_flush_done_nxt = 1'b1;
                        if (w_sum != 7'd0) begin
                            w_out_valid_nxt = 1'b1;
                            w_out_word_nxt  = w_acc_app[63:32];
                        end
                        w_acc_nxt  = 64'd0;
                        w_fill_nxt = 6'd0;
                    end
                end
            end
            FLUSH_TAIL: begin
                w_flush_done_nxt = 1'b1;
                if (r_fill != 6'd0) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_word_nxt  = r_acc[63:32];
                end
                w_acc_nxt   = 64'd0;
                w_fill_nxt  = 6'd0;
                w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_acc        <= 64'd0;
            r_fill       <= 6'd0;
            r_out_valid  <= 1'b0;
            r_out_word   <= 32'd0;
            r_flush_done <= 1'b0;
            r_total      <= 32'd0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_fill       <= w_fill_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_word   <= w_out_word_nxt;
            r_flush_done <= w_flush_done_nxt;
            r_total      <= w_total_nxt;
            r_len_err    <= w_len_err_nxt;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_word   = r_out_word;
    assign bus.flush_done = r_flush_done;
    assign bus.total_bits = r_total;
    assign bus.len_err    = r_len_err;
endmodule

// File: tb/tb_vlc_bit_packer.sv
// Scoreboard bench for vlc_bit_packer: a bit-queue reference model predicts
// every output event; a negedge monitor pops and compares.
module tb_vlc_bit_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    vlc_bit_packer_if bus ();

    vlc_bit_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          has_word;
        logic [31:0] word;
        bit          fd;
        logic [31:0] tot;
        int          cyc;
    } ev_t;

    ev_t  exp_q[$];
    bit   mq[$];
    logic [31:0] m_total = 0;
    bit   m_lenerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the stream is just a FIFO of bits; words are its 32-bit slices.
    task automatic apply(input bit v, input logic [31:0] code, input int len, input bit fl);
        ev_t e;
        bit  full_this;
        int  n;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_code  = code;
        bus.in_len   = 6'(len);
        bus.flush    = fl;
        full_this = 0;
        if (v && len > 32) begin
            m_lenerr = 1;
        end else if (v) begin
            for (int i = len - 1; i >= 0; i--) mq.push_back(code[i]);
            m_total += 32'(len);
        end
        if (mq.size() >= 32) begin
            e.word = 0;
            for (int i = 0; i < 32; i++) e.word = {e.word[30:0], mq.pop_front()};
            e.has_word = 1; e.fd = 0; e.tot = 0; e.cyc = cyc + 1;
            exp_q.push_back(e);
            full_this = 1;
        end
        if (fl) begin
            n = mq.size();
            e.word = 0;
            for (int i = 0; i < 32; i++) e.word = {e.word[30:0], (i < n) ? mq.pop_front() : 1'b0};
            e.has_word = (n > 0);
            e.fd  = 1;
            e.tot = m_total;
            e.cyc = cyc + (full_this ? 2 : 1);
            exp_q.push_back(e);
            m_total = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 32'd0, 0, 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_total_bits"}, bus.total_bits, m_total);
        chk({tag, "_len_err"}, 32'(bus.len_err), 32'(m_lenerr));
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.out_valid || bus.flush_done)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: out_valid=%0b out_word=0x%08h flush_done=%0b, expected nothing (cycle %0d)",
                         bus.out_valid, bus.out_word, bus.flush_done, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("out_valid", 32'(bus.out_valid), 32'(e.has_word));
                if (e.has_word) chk("out_word", bus.out_word, e.word);
                chk("flush_done", 32'(bus.flush_done), 32'(e.fd));
                if (e.fd) chk("total_at_flush", bus.total_bits, e.tot);
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_code = 0; bus.in_len = 0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_word", bus.out_word, 0);
        chk("rst_flush_done", 32'(bus.flush_done), 0);
        chk("rst_total_bits", bus.total_bits, 0);
        chk("rst_len_err", 32'(bus.len_err), 0);
        @(posedge clk); #1; reset = 0;
        idle(2);

        // four bytes -> one word
        apply(1, 32'hAB, 8, 0); apply(1, 32'hCD, 8, 0);
        apply(1, 32'hEF, 8, 0); apply(1, 32'h12, 8, 0);
        idle(2);
        check_state("four_bytes");
        apply(0, 0, 0, 1); idle(3);
        check_state("after_flush0");

        // 3 + 30 bits, then flush of the 1-bit residue (upper code bits masked)
        apply(1, 32'hFFFF_FFFD, 3, 0); apply(1, 32'h3FFF_FFFF, 30, 0);
        apply(0, 0, 0, 1); idle(3);
        check_state("flush_residue");

        // 5 bits then flush
        apply(1, 32'h16, 5, 0); apply(0, 0, 0, 1); idle(3);
        check_state("flush_5");

        // fill=31 plus 2 bits with simultaneous flush -> FLUSH_TAIL path
        apply(1, 32'h7FFF_FFFF, 31, 0); apply(1, 32'h3, 2, 1); idle(3);
        check_state("flush_tail");

        // exact 32-bit fill with flush -> flush_done without residue word
        apply(1, 32'h1234_5678, 32, 1); idle(3);
        check_state("flush_exact");

        // bad length and zero length leave fill untouched
        apply(1, 32'h3, 4, 0); apply(1, 32'hFFFF, 40, 0); apply(1, 32'hFFFF, 0, 0);
        idle(2);
        check_state("len_err");
        apply(0, 0, 0, 1); idle(3);

        // reset with partial fill
        apply(1, 32'hABCDE, 20, 0); idle(1);
        @(posedge clk); #1; reset = 1;
        mq.delete(); m_total = 0; m_lenerr = 0;
        #12;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_out_word", bus.out_word, 0);
        chk("midrst_flush_done", 32'(bus.flush_done), 0);
        chk("midrst_total_bits", bus.total_bits, 0);
        chk("midrst_len_err", 32'(bus.len_err), 0);
        @(posedge clk); #1; reset = 0;
        idle(1);
        apply(1, 32'hDEAD_BEEF, 32, 0); idle(2);
        check_state("post_reset");
        apply(0, 0, 0, 1); idle(3);

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            bit v, fl;
            int len;
            v   = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 49) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            fl  = ($urandom_range(0, 15) == 0);
            apply(v, $urandom, len, fl);
            if (fl) begin
                idle(3);
                check_state("rand");
            end
        end
        apply(0, 0, 0, 1); idle(5);
        check_state("final");
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
